// File: rtl/down_timer.sv
`default_nettype none
// ============================================================================
// Module   : down_timer
// Purpose  : Loadable down-counter/timer with one-shot and periodic modes.
// Revision : 1.0 - initial release
// ============================================================================
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             tc_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            count_q  <= c_ZERO;
            reload_q <= c_ZERO;
            tc_q     <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        count_q  <= load_value;
                        reload_q <= load_value;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else if (start) begin
                        count_q  <= load_value;
                        reload_q <= load_value;
                    end else if (enable) begin
                        if (count_q != c_ZERO) begin
                            count_q <= count_q - c_ONE;
                        end else begin
                            // Zero is processed for one full cycle before tc fires.
                            tc_q <= 1'b1;
                            if (auto_reload) begin
                                count_q <= reload_q;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Q    = count_q;
    assign busy = (state_q == ST_RUN);
    assign tc   = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_down_timer
// Purpose  : Self-checking bench for down_timer (vectors, corners, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_down_timer;

    localparam int WIDTH = 8;

    logic             clock;
    logic             clear;
    logic             start;
    logic             stop;
    logic             enable;
    logic             auto_reload;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] Q;
    logic             busy;
    logic             tc;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: plain integers describing what the timer should show.
    int m_q      = 0;
    int m_reload = 0;
    bit m_run    = 0;
    bit m_tc     = 0;

    down_timer #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .stop        (stop),
        .enable      (enable),
        .auto_reload (auto_reload),
        .load_value  (load_value),
        .Q           (Q),
        .busy        (busy),
        .tc          (tc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit clr, st, sp, en, ar;
        int lv;
        int q;
        bit b, t;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit clr, bit st, bit sp, bit en, bit ar, int lv,
                                int q, bit b, bit t);
        vec_t v;
        v.clr = clr; v.st = st; v.sp = sp; v.en = en; v.ar = ar; v.lv = lv;
        v.q = q; v.b = b; v.t = t;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Timer rules evaluated on the inputs present at the edge.
    task automatic model_edge();
        m_tc = 1'b0;
        if (clear) begin
            m_q = 0; m_reload = 0; m_run = 1'b0;
        end else if (!m_run) begin
            if (start) begin
                m_q = int'(load_value); m_reload = int'(load_value); m_run = 1'b1;
            end
        end else if (stop) begin
            m_run = 1'b0;
        end else if (start) begin
            m_q = int'(load_value); m_reload = int'(load_value);
        end else if (enable) begin
            if (m_q > 0) m_q = m_q - 1;
            else begin
                m_tc = 1'b1;
                if (auto_reload) m_q = m_reload;
                else m_run = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        model_edge();
        chk("model", {int'(Q), 1'b0, busy, tc} == {m_q, 1'b0, m_run, m_tc} ? 1 : 0, 1);
    endtask

    task automatic set_in(bit clr, bit st, bit sp, bit en, bit ar, int lv);
        clear = clr; start = st; stop = sp; enable = en; auto_reload = ar;
        load_value = WIDTH'(lv);
    endtask

    task automatic expect3(input string name, input int q, input bit b, input bit t);
        chk({name, ".Q"}, int'(Q), q);
        chk({name, ".busy"}, int'(busy), int'(b));
        chk({name, ".tc"}, int'(tc), int'(t));
    endtask

    initial begin
        int tc_edge;
        set_in(1, 0, 0, 0, 0, 0);

        // Reset with random noise on the other inputs
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)));
            step();
            expect3("reset", 0, 0, 0);
        end
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 1, 1, 7);
            step();
            expect3("post_reset", 0, 0, 0);
        end

        // One-shot, N=5; load_value changed mid-run must be ignored
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 5,  5, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 99, 4, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 99, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 99, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 99, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 99, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 99, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 99, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 99, 0, 0, 0));
        // load_value=0 one-shot: tc after edge 1
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,  0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 1));
        foreach (vecs[i]) begin
            set_in(vecs[i].clr, vecs[i].st, vecs[i].sp, vecs[i].en, vecs[i].ar, vecs[i].lv);
            step();
            expect3($sformatf("vec%0d", i), vecs[i].q, vecs[i].b, vecs[i].t);
        end

        // Periodic N=3: tc after edges 4, 8, 12
        set_in(0, 1, 0, 1, 1, 3);
        step();
        expect3("per.start", 3, 1, 0);
        set_in(0, 0, 0, 1, 1, 3);
        for (int i = 1; i <= 12; i++) begin
            step();
            expect3($sformatf("per.e%0d", i), 3 - (i % 4), 1, (i % 4) == 0);
        end
        // Restart with N=0: tc every cycle
        set_in(0, 1, 0, 1, 1, 0);
        step();
        expect3("per0.start", 0, 1, 0);
        set_in(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            expect3("per0.run", 0, 1, 1);
        end

        // Pause and stop
        set_in(1, 0, 0, 0, 0, 0); step();
        set_in(0, 1, 0, 1, 0, 10); step();
        expect3("ps.start", 10, 1, 0);
        set_in(0, 0, 0, 1, 0, 10);
        for (int i = 9; i >= 7; i--) begin step(); expect3("ps.cnt", i, 1, 0); end
        set_in(0, 0, 0, 0, 0, 10);
        for (int i = 0; i < 3; i++) begin step(); expect3("ps.pause", 7, 1, 0); end
        set_in(0, 0, 0, 1, 0, 10);
        for (int i = 6; i >= 4; i--) begin step(); expect3("ps.resume", i, 1, 0); end
        set_in(0, 0, 1, 1, 0, 10); step();
        expect3("ps.stop", 4, 0, 0);
        set_in(0, 0, 0, 1, 1, 10);
        for (int i = 0; i < 6; i++) begin step(); expect3("ps.idle", 4, 0, 0); end

        // start + stop together in RUN
        set_in(0, 1, 0, 1, 0, 9); step();
        set_in(0, 0, 0, 1, 0, 9); step();
        expect3("ss.cnt", 8, 1, 0);
        set_in(0, 1, 1, 1, 0, 3); step();
        expect3("ss.both", 8, 0, 0);

        // start on the Q==0 cycle
        set_in(0, 1, 0, 1, 0, 2); step();
        set_in(0, 0, 0, 1, 0, 2); step(); step();
        expect3("sz.zero", 0, 1, 0);
        set_in(0, 1, 0, 1, 0, 6); step();
        expect3("sz.restart", 6, 1, 0);

        // clear on the Q==0 cycle
        set_in(0, 1, 0, 1, 0, 1); step();
        set_in(0, 0, 0, 1, 0, 1); step();
        expect3("cz.zero", 0, 1, 0);
        set_in(1, 0, 0, 1, 0, 1); step();
        expect3("cz.clear", 0, 0, 0);

        // enable dropped exactly at Q==0 delays tc
        set_in(0, 1, 0, 1, 0, 1); step();
        set_in(0, 0, 0, 1, 0, 1); step();
        set_in(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin step(); expect3("ez.hold", 0, 1, 0); end
        set_in(0, 0, 0, 1, 0, 1); step();
        expect3("ez.tc", 0, 0, 1);

        // Max value one-shot: tc exactly 256 edges after start, no wrap
        set_in(0, 1, 0, 1, 0, 255); step();
        expect3("max.start", 255, 1, 0);
        set_in(0, 0, 0, 1, 0, 255);
        tc_edge = -1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i <= 255) chk("max.Q", int'(Q), 255 - i);
            if (tc) begin tc_edge = i; break; end
        end
        chk("max.tc_edge", tc_edge, 256);
        chk("max.final_Q", int'(Q), 0);

        // Randomized traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                   ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                   1'($urandom),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 12)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
